led_write_sched: RTL and testbench
==================================

Name: led_write_sched

Overview:
- Sequencer and arbiter in front of the 3-lane memory-mapped LED register.
- Two requesters share the register:
  - the CPU MMIO path, which issues byte-lane-masked 24-bit updates;
  - a pattern/status engine, which issues full 24-bit updates.
- Grants one requester at a time, latches its 24-bit value, and replays it as 1-cycle byte writes on the LED register's write port (lane 0, then 1, then 2).

Parameters:
- LANE_GAP, 0, idle cycles inserted between consecutive lane writes (0..7).
- PAT_MASK, 3'b111, lane mask applied to every pattern-engine request.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU update request; level, held until cpu_ack.
- cpu_data  in  24  CPU value; bits [8k+7:8k] go to lane k.
- cpu_mask  in  3  lanes to write; bit k enables lane k.
- cpu_ack  out  1  1-cycle pulse: request accepted, data latched.
- pat_req  in  1  pattern request; level, held until pat_ack.
- pat_data  in  24  pattern value.
- pat_ack  out  1  1-cycle pulse: pattern request accepted.
- led_ctrl  out  1  LED register select strobe.
- io_write  out  1  write strobe; always equal to led_ctrl.
- write_data  out  16  {8'h00, lane byte}.
- led_addr  out  2  lane: 2'b00, 2'b01 or 2'b10; 2'b11 is never driven.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched data and mask 0.
- Reset mid-sequence aborts it. No further lane writes occur and the pending transaction is dropped with no re-ack. The LED register resets on the same reset, so no partial lane state survives.
- All outputs are registered.
- States:
  - IDLE.
  - WR: drive one lane write.
  - GAP: count LANE_GAP cycles.
- IDLE arbitration at each rising edge:
  - Default is fixed priority, CPU over pattern.
  - On grant: latch the granted requester's data and mask (PAT_MASK for the pattern engine).
  - Next cycle: the matching ack is 1.
- The transition out of IDLE on grant depends on the latched mask:
  - mask != 0: go to WR and drive the lowest enabled lane in the same cycle as the ack.
  - mask == 0: ack only, stay IDLE, no write.
- WR cycle drives:
  - led_ctrl = io_write = 1;
  - led_addr = lane index;
  - write_data[7:0] = latched byte of that lane, write_data[15:8] = 0.
- Lanes with a 0 mask bit are skipped; they consume no cycles.
- After each WR:
  - another enabled lane remains and LANE_GAP > 0: go to GAP for exactly LANE_GAP cycles (strobes 0), then WR the next lane;
  - another enabled lane remains and LANE_GAP = 0: WR the next lane directly;
  - no enabled lane remains: go to IDLE.
- Throughput:
  - LANE_GAP = 0, full mask: 3 consecutive write cycles.
  - A new grant can be taken on the edge leaving IDLE, so the minimum spacing between sequences is 1 IDLE cycle.
- Request inputs are sampled only in IDLE. Changes to req/data while busy are ignored until the next IDLE sample. Requesters must hold req until ack.
- Simultaneous cpu_req and pat_req: only one ack per grant. The loser remains pending.
- Ack and write strobes never go to a requester that was not granted.

Optional Feature:
- Macro: LED_WRITE_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset: pattern) flips priority after every grant.
  - With both requesting continuously, grants alternate cpu, pat, cpu, and so on.
- Undefined: fixed CPU priority; the pattern engine may starve.

Decomposition:
- Shared package led_pkg:
  - lane address constants LED_LANE0/1/2 = 2'b00/01/10;
  - state enum {IDLE, WR, GAP};
  - LED_LANES = 3, LED_BYTE_W = 8.
- One natural sub-module, led_lane_pick: combinational next-enabled-lane finder. Inputs: mask and current lane. Outputs: next lane index and a valid flag.

Test Plan:
- Reset, then cpu_req with cpu_data=24'hA1B2C3, mask=3'b111, LANE_GAP=0 -> ack cycle plus 3 consecutive writes: (00, 16'h00C3), (01, 16'h00B2), (10, 16'h00A1); busy low afterwards.
- cpu mask=3'b101, data=24'h112233 -> writes only (00, 0x33) then (10, 0x11) on back-to-back cycles; lane 01 never strobed.
- cpu_req and pat_req together, pat_data=24'hFFFFFF:
  - default build -> cpu served first, pat_ack after the cpu sequence;
  - with LED_WRITE_SCHED_RR_EN -> grants alternate over 4 sequences.
- LANE_GAP=2, full mask -> writes at relative cycles 0, 3, 6; strobes low in between.
- Assert reset while the lane 01 write is being driven -> all outputs 0 next cycle, lane 10 never written, no ack repeated; a new request after reset runs normally.
- cpu mask=3'b000 -> one cpu_ack pulse, zero write strobes, busy stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared lane constants, state encoding and byte-lane helper for the LED write scheduler.
package led_pkg;

  localparam int LED_LANES  = 3;
  localparam int LED_BYTE_W = 8;
  localparam int LED_DATA_W = LED_LANES * LED_BYTE_W;

  localparam logic [1:0] LED_LANE0 = 2'b00;
  localparam logic [1:0] LED_LANE1 = 2'b01;
  localparam logic [1:0] LED_LANE2 = 2'b10;

  typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

  function automatic logic [LED_BYTE_W-1:0] lane_byte(input logic [LED_DATA_W-1:0] data,
                                                      input logic [1:0]            lane);
    case (lane)
      LED_LANE0: return data[7:0];
      LED_LANE1: return data[15:8];
      LED_LANE2: return data[23:16];
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_lane_pick.sv
// Combinational finder: lowest enabled lane whose index is >= i_from.
module led_lane_pick
  import led_pkg::*;
(
  input  logic [LED_LANES-1:0] i_mask,
  input  logic [2:0]           i_from,
  output logic [1:0]           o_lane,
  output logic                 o_valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_lane  = LED_LANE0;
    o_valid = 1'b0;
    // Scan downward so the lowest qualifying lane is the last one written.
    for (int k = LED_LANES - 1; k >= 0; k--) begin
      if (i_mask[k] && (3'(k) >= i_from)) begin
        o_lane  = 2'(k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_write_sched.sv
// Arbitrates CPU and pattern updates and replays the granted 24-bit value as byte-lane writes.
// Define LED_WRITE_SCHED_RR_EN for round-robin arbitration; default is fixed CPU priority.
module led_write_sched
  import led_pkg::*;
#(
  parameter int                  LANE_GAP = 0,
  parameter logic [LED_LANES-1:0] PAT_MASK = 3'b111
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [LED_DATA_W-1:0] cpu_data,
  input  logic [LED_LANES-1:0]  cpu_mask,
  output logic                  cpu_ack,
  input  logic                  pat_req,
  input  logic [LED_DATA_W-1:0] pat_data,
  output logic                  pat_ack,
  output logic                  led_ctrl,
  output logic                  io_write,
  output logic [15:0]           write_data,
  output logic [1:0]            led_addr,
  output logic                  busy
);

  localparam logic [2:0] GAP_LOAD = (LANE_GAP > 0) ? 3'(LANE_GAP - 1) : 3'd0;

  state_t                r_state;
  logic [LED_DATA_W-1:0] r_data;
  logic [LED_LANES-1:0]  r_mask;
  logic [1:0]            r_lane;
  logic [2:0]            r_gap_cnt;
  logic                  r_cpu_ack, r_pat_ack, r_strobe, r_busy;
  logic [1:0]            r_addr;
  logic [LED_BYTE_W-1:0] r_wbyte;

  logic                  w_gnt_cpu, w_gnt_pat;
  logic [LED_DATA_W-1:0] w_gnt_data;
  logic [LED_LANES-1:0]  w_gnt_mask;
  logic [1:0]            w_first_lane, w_next_lane;
  logic                  w_first_vld, w_next_vld;
  logic [LED_BYTE_W-1:0] w_next_byte;

`ifdef LED_WRITE_SCHED_RR_EN
  logic r_last_pat;  // 1: pattern engine held the most recent grant
  assign w_gnt_cpu = cpu_req && (r_last_pat || !pat_req);
`else
  assign w_gnt_cpu = cpu_req;
`endif
  assign w_gnt_pat  = pat_req && !w_gnt_cpu;
  assign w_gnt_data = w_gnt_cpu ? cpu_data : pat_data;
  assign w_gnt_mask = w_gnt_cpu ? cpu_mask : PAT_MASK;

  led_lane_pick u_first_pick (
    .i_mask  (w_gnt_mask),
    .i_from  (3'd0),
    .o_lane  (w_first_lane),
    .o_valid (w_first_vld)
  );

  led_lane_pick u_next_pick (
    .i_mask  (r_mask),
    .i_from  ({1'b0, r_lane} + 3'd1),
    .o_lane  (w_next_lane),
    .o_valid (w_next_vld)
  );

  assign w_next_byte = lane_byte(r_data, w_next_lane);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_mask    <= '0;
      r_lane    <= LED_LANE0;
      r_gap_cnt <= '0;
      r_cpu_ack <= 1'b0;
      r_pat_ack <= 1'b0;
      r_strobe  <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= LED_LANE0;
      r_wbyte   <= '0;
`ifdef LED_WRITE_SCHED_RR_EN
      r_last_pat <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking everywhere here; later assignments in the case override these pulse defaults.
      r_cpu_ack <= 1'b0;
      r_pat_ack <= 1'b0;
      r_strobe  <= 1'b0;
      r_addr    <= LED_LANE0;
      r_wbyte   <= '0;
      case (r_state)
        IDLE: begin
          if (w_gnt_cpu || w_gnt_pat) begin
            r_cpu_ack <= w_gnt_cpu;
            r_pat_ack <= w_gnt_pat;
            r_data    <= w_gnt_data;
            r_mask    <= w_gnt_mask;
`ifdef LED_WRITE_SCHED_RR_EN
            r_last_pat <= w_gnt_pat;
`endif
            // An empty mask is acknowledged without leaving IDLE.
            if (w_first_vld) begin
              r_state  <= WR;
              r_busy   <= 1'b1;
              r_strobe <= 1'b1;
              r_lane   <= w_first_lane;
              r_addr   <= w_first_lane;
              r_wbyte  <= lane_byte(w_gnt_data, w_first_lane);
            end
          end
        end
        WR: begin
          if (!w_next_vld) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (LANE_GAP > 0) begin
            r_state   <= GAP;
            r_gap_cnt <= GAP_LOAD;
          end else begin
            r_strobe <= 1'b1;
            r_lane   <= w_next_lane;
            r_addr   <= w_next_lane;
            r_wbyte  <= w_next_byte;
          end
        end
        GAP: begin
          if (r_gap_cnt == 3'd0) begin
            r_state  <= WR;
            r_strobe <= 1'b1;
            r_lane   <= w_next_lane;
            r_addr   <= w_next_lane;
            r_wbyte  <= w_next_byte;
          end else begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack    = r_cpu_ack;
  assign pat_ack    = r_pat_ack;
  assign led_ctrl   = r_strobe;
  assign io_write   = r_strobe;
  assign write_data = {8'h00, r_wbyte};
  assign led_addr   = r_addr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_led_write_sched.sv
// Directed bench for led_write_sched: one instance with LANE_GAP=0, one with LANE_GAP=2.
module tb_led_write_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, pat_req = 1'b0;
  logic [23:0] cpu_data = '0, pat_data = '0;
  logic [2:0]  cpu_mask = '0;
  logic        cpu_ack, pat_ack, led_ctrl, io_write, busy;
  logic [15:0] write_data;
  logic [1:0]  led_addr;

  logic        g_cpu_req = 1'b0;
  logic [23:0] g_cpu_data = '0;
  logic [2:0]  g_cpu_mask = '0;
  logic        g_cpu_ack, g_pat_ack, g_led_ctrl, g_io_write, g_busy;
  logic [15:0] g_write_data;
  logic [1:0]  g_led_addr;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  led_write_sched #(.LANE_GAP(0)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_mask(cpu_mask), .cpu_ack(cpu_ack),
    .pat_req(pat_req), .pat_data(pat_data), .pat_ack(pat_ack),
    .led_ctrl(led_ctrl), .io_write(io_write), .write_data(write_data),
    .led_addr(led_addr), .busy(busy)
  );

  led_write_sched #(.LANE_GAP(2)) dut_gap (
    .clock(clock), .reset(reset),
    .cpu_req(g_cpu_req), .cpu_data(g_cpu_data), .cpu_mask(g_cpu_mask), .cpu_ack(g_cpu_ack),
    .pat_req(1'b0), .pat_data(24'h0), .pat_ack(g_pat_ack),
    .led_ctrl(g_led_ctrl), .io_write(g_io_write), .write_data(g_write_data),
    .led_addr(g_led_addr), .busy(g_busy)
  );

  // Observation vector: {cpu_ack, pat_ack, led_ctrl, io_write, busy, led_addr, write_data}
  function automatic logic [22:0] obs0();
    return {cpu_ack, pat_ack, led_ctrl, io_write, busy, led_addr, write_data};
  endfunction

  function automatic logic [22:0] obs1();
    return {g_cpu_ack, g_pat_ack, g_led_ctrl, g_io_write, g_busy, g_led_addr, g_write_data};
  endfunction

  function automatic logic [22:0] ev(input logic ca, input logic pa, input logic st,
                                     input logic bz, input logic [1:0] a, input logic [7:0] b);
    return {ca, pa, st, st, bz, a, 8'h00, b};
  endfunction

  task automatic check(input string tag, input logic [22:0] observed, input logic [22:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full sequence on the LANE_GAP=0 instance: grant cycle, remaining lanes, one IDLE cycle.
  task automatic seq(input string tag, input logic ca, input logic pa, input logic [23:0] data,
                     input logic [2:0] mask, input logic drop_c, input logic drop_p);
    logic first;
    logic [23:0] d;
    first = 1'b1;
    d = data;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        tick();
        check($sformatf("%s_lane%0d", tag, k), obs0(),
              ev(first & ca, first & pa, 1'b1, 1'b1, 2'(k), d[k*8 +: 8]));
        if (first) begin
          if (drop_c) cpu_req = 1'b0;
          if (drop_p) pat_req = 1'b0;
        end
        first = 1'b0;
      end
    end
    tick();
    check({tag, "_idle"}, obs0(), '0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out", obs0(), '0);
    check("rst_out_gap", obs1(), '0);
    reset = 1'b0;
    tick();
    check("idle_noreq", obs0(), '0);

    // Full-mask CPU update, back-to-back lanes
    cpu_data = 24'hA1B2C3; cpu_mask = 3'b111; cpu_req = 1'b1;
    seq("t1", 1'b1, 1'b0, 24'hA1B2C3, 3'b111, 1'b1, 1'b0);

    // Sparse mask: lane 1 skipped without a cycle
    cpu_data = 24'h112233; cpu_mask = 3'b101; cpu_req = 1'b1;
    seq("t2", 1'b1, 1'b0, 24'h112233, 3'b101, 1'b1, 1'b0);

    // Simultaneous requests
    cpu_data = 24'h445566; cpu_mask = 3'b111; pat_data = 24'hFFFFFF;
    cpu_req = 1'b1; pat_req = 1'b1;
`ifdef LED_WRITE_SCHED_RR_EN
    // Last grant was CPU, so the pattern engine goes first, then they alternate.
    seq("rr0", 1'b0, 1'b1, 24'hFFFFFF, 3'b111, 1'b0, 1'b0);
    seq("rr1", 1'b1, 1'b0, 24'h445566, 3'b111, 1'b0, 1'b0);
    seq("rr2", 1'b0, 1'b1, 24'hFFFFFF, 3'b111, 1'b0, 1'b0);
    seq("rr3", 1'b1, 1'b0, 24'h445566, 3'b111, 1'b1, 1'b1);
    pat_req = 1'b0;
    tick();
    check("rr_done", obs0(), '0);
`else
    seq("fp_cpu", 1'b1, 1'b0, 24'h445566, 3'b111, 1'b1, 1'b0);
    seq("fp_pat", 1'b0, 1'b1, 24'hFFFFFF, 3'b111, 1'b0, 1'b1);
`endif

    // LANE_GAP=2: writes at relative cycles 0, 3, 6
    g_cpu_data = 24'h5A6B7C; g_cpu_mask = 3'b111; g_cpu_req = 1'b1;
    tick();
    check("gap_c0", obs1(), ev(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 8'h7C));
    g_cpu_req = 1'b0;
    tick(); check("gap_c1", obs1(), ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00));
    tick(); check("gap_c2", obs1(), ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00));
    tick(); check("gap_c3", obs1(), ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 8'h6B));
    tick(); check("gap_c4", obs1(), ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00));
    tick(); check("gap_c5", obs1(), ev(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00));
    tick(); check("gap_c6", obs1(), ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 8'h5A));
    tick(); check("gap_c7", obs1(), '0);

    // Reset while lane 01 is being driven
    cpu_data = 24'h778899; cpu_mask = 3'b111; cpu_req = 1'b1;
    tick();
    check("rm_lane0", obs0(), ev(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 8'h99));
    cpu_req = 1'b0;
    tick();
    check("rm_lane1", obs0(), ev(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 8'h88));
    reset = 1'b1;
    tick();
    check("rm_reset", obs0(), '0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rm_after%0d", i), obs0(), '0);
    end
    cpu_data = 24'h010203; cpu_mask = 3'b111; cpu_req = 1'b1;
    seq("rm_new", 1'b1, 1'b0, 24'h010203, 3'b111, 1'b1, 1'b0);

    // Empty mask: ack only, no strobes, never busy
    cpu_data = 24'hDEADBE; cpu_mask = 3'b000; cpu_req = 1'b1;
    tick();
    check("m0_ack", obs0(), ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
    cpu_req = 1'b0;
    tick(); check("m0_after1", obs0(), '0);
    tick(); check("m0_after2", obs0(), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
